// File: rtl/sha256_pkg.sv
// Shared definitions for the SHA-256 message input buffer.
// Holds the block geometry, the buffer state encoding, the word type and a
// popcount helper used to derive the written-word count from the write mask.
package sha256_pkg;

   localparam int WORD_W  = 32;
   localparam int N_WORDS = 16;
   localparam int ADDR_W  = 4;
   localparam int CNT_W   = 5;

   localparam logic [N_WORDS-1:0] MASK_EMPTY = 16'h0000;
   localparam logic [N_WORDS-1:0] MASK_FULL  = 16'hFFFF;

   typedef logic [31:0] word_t;

   typedef enum logic {
      ST_FILL  = 1'b0,
      ST_READY = 1'b1
   } buf_state_t;

   // Number of set bits in a 16-bit write mask (0..16).
   function automatic logic [CNT_W-1:0] popcount16(input logic [N_WORDS-1:0] m);
      logic [CNT_W-1:0] cnt;
      cnt = 5'd0;
      for (int i = 0; i < N_WORDS; i++) begin
         cnt = cnt + {4'd0, m[i]};
      end
      return cnt;
   endfunction

endpackage

// File: rtl/input_buffer_ctrl.sv
// Control path of the message input buffer.
// Tracks which words have been written (mask), owns the FILL/READY handshake
// with the compression core and produces the one-cycle error pulses.
// Ports:
//   clk, rst      : clock, synchronous active-high reset
//   addr, we      : host write index and strobe
//   load          : host commit request
//   ack           : core release pulse
//   mem_we        : storage write enable (combinational, FILL only)
//   block_valid   : block owned by core
//   full          : all words written since last release
//   word_cnt      : distinct words written
//   wr_err        : write attempted while block owned by core
//   load_err      : commit while incomplete or while block owned by core
module input_buffer_ctrl
   import sha256_pkg::*;
(
   input  logic              clk,
   input  logic              rst,
   input  logic [ADDR_W-1:0] addr,
   input  logic              we,
   input  logic              load,
   input  logic              ack,
   output logic              mem_we,
   output logic              block_valid,
   output logic              full,
   output logic [CNT_W-1:0]  word_cnt,
   output logic              wr_err,
   output logic              load_err
);

   buf_state_t         state_r;
   buf_state_t         state_nx;
   logic [N_WORDS-1:0] mask_r;
   logic [N_WORDS-1:0] mask_nx;
   logic [N_WORDS-1:0] wr_mask_s;
   logic               mem_we_s;
   logic               wr_err_nx;
   logic               load_err_nx;
   logic               block_valid_r;
   logic               full_r;
   logic [CNT_W-1:0]   word_cnt_r;
   logic               wr_err_r;
   logic               load_err_r;

   // Next-state, mask update and error decode for the FILL/READY handshake.
   always_comb begin
      state_nx    = state_r;
      mask_nx     = mask_r;
      wr_mask_s   = mask_r;
      mem_we_s    = 1'b0;
      wr_err_nx   = 1'b0;
      load_err_nx = 1'b0;
      case (state_r)
         ST_FILL: begin
            if (we) begin
               mem_we_s  = 1'b1;
               wr_mask_s = mask_r | ({{(N_WORDS-1){1'b0}}, 1'b1} << addr);
            end else begin
               wr_mask_s = mask_r;
            end
            mask_nx = wr_mask_s;
            // Completeness includes a write landing in the same cycle.
            if (load) begin
               if (wr_mask_s == MASK_FULL) begin
                  state_nx = ST_READY;
               end else begin
                  load_err_nx = 1'b1;
               end
            end else begin
               state_nx = ST_FILL;
            end
         end
         ST_READY: begin
            // Host activity is dropped and flagged, never deferred.
            wr_err_nx   = we;
            load_err_nx = load;
            if (ack) begin
               state_nx = ST_FILL;
               mask_nx  = MASK_EMPTY;
            end else begin
               state_nx = ST_READY;
            end
         end
         default: begin
            state_nx = ST_FILL;
            mask_nx  = MASK_EMPTY;
         end
      endcase
   end

   // State, mask and registered status outputs.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_r       <= ST_FILL;
         mask_r        <= MASK_EMPTY;
         block_valid_r <= 1'b0;
         full_r        <= 1'b0;
         word_cnt_r    <= 5'd0;
         wr_err_r      <= 1'b0;
         load_err_r    <= 1'b0;
      end else begin
         state_r       <= state_nx;
         mask_r        <= mask_nx;
         block_valid_r <= (state_nx == ST_READY);
         full_r        <= (mask_nx == MASK_FULL);
         word_cnt_r    <= popcount16(mask_nx);
         wr_err_r      <= wr_err_nx;
         load_err_r    <= load_err_nx;
      end
   end

   assign mem_we      = mem_we_s;
   assign block_valid = block_valid_r;
   assign full        = full_r;
   assign word_cnt    = word_cnt_r;
   assign wr_err      = wr_err_r;
   assign load_err    = load_err_r;

endmodule

// File: rtl/input_buffer.sv
// SHA-256 message input buffer (write-side counterpart of the output buffer).
// The host fills 16 words by index and commits; the core then reads W[0..15]
// by index and acknowledges, returning the buffer to the host.
// Ports:
//   clk, rst    : clock, synchronous active-high reset
//   addr, we    : host write index and strobe
//   in_var      : host write data
//   load        : host commit request
//   rd_addr     : core read index
//   ack         : core release pulse
//   out_var     : registered word at rd_addr (1-cycle latency)
//   block_valid, full, word_cnt, wr_err, load_err : status, see control path
module input_buffer
   import sha256_pkg::*;
(
   input  logic              clk,
   input  logic              rst,
   input  logic [ADDR_W-1:0] addr,
   input  logic              we,
   input  logic [WORD_W-1:0] in_var,
   input  logic              load,
   input  logic [ADDR_W-1:0] rd_addr,
   input  logic              ack,
   output logic [WORD_W-1:0] out_var,
   output logic              block_valid,
   output logic              full,
   output logic [CNT_W-1:0]  word_cnt,
   output logic              wr_err,
   output logic              load_err
);

   word_t mem_r [N_WORDS];
   word_t out_var_r;
   logic  mem_we_s;

   input_buffer_ctrl u_ctrl (
      .clk         (clk),
      .rst         (rst),
      .addr        (addr),
      .we          (we),
      .load        (load),
      .ack         (ack),
      .mem_we      (mem_we_s),
      .block_valid (block_valid),
      .full        (full),
      .word_cnt    (word_cnt),
      .wr_err      (wr_err),
      .load_err    (load_err)
   );

   // Word storage; deliberately not reset, contents are meaningful only once written.
   always_ff @(posedge clk) begin
      if (mem_we_s) begin
         mem_r[addr] <= in_var;
      end else begin
         mem_r[addr] <= mem_r[addr];
      end
   end

   // Registered read port, active in every state.
   always_ff @(posedge clk) begin
      if (rst) begin
         out_var_r <= 32'h0000_0000;
      end else begin
         out_var_r <= mem_r[rd_addr];
      end
   end

   assign out_var = out_var_r;

endmodule

// File: tb/tb_input_buffer.sv
// Directed self-checking bench for input_buffer.
module tb_input_buffer;

   logic        clk;
   logic        rst;
   logic [3:0]  addr;
   logic        we;
   logic [31:0] in_var;
   logic        load;
   logic [3:0]  rd_addr;
   logic        ack;
   logic [31:0] out_var;
   logic        block_valid;
   logic        full;
   logic [4:0]  word_cnt;
   logic        wr_err;
   logic        load_err;

   int checks;
   int failures;

   input_buffer dut (
      .clk         (clk),
      .rst         (rst),
      .addr        (addr),
      .we          (we),
      .in_var      (in_var),
      .load        (load),
      .rd_addr     (rd_addr),
      .ack         (ack),
      .out_var     (out_var),
      .block_valid (block_valid),
      .full        (full),
      .word_cnt    (word_cnt),
      .wr_err      (wr_err),
      .load_err    (load_err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   // One clock edge; inputs set before it take effect, outputs read 1 time unit after.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic write_word(input logic [3:0] a, input logic [31:0] d);
      addr   = a;
      in_var = d;
      we     = 1'b1;
      step();
      we     = 1'b0;
   endtask

   // Fill all 16 words with base+k, then commit.
   task automatic fill_and_load(input logic [31:0] base);
      for (int k = 0; k < 16; k++) begin
         write_word(k[3:0], base + k);
      end
      load = 1'b1;
      step();
      load = 1'b0;
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, "_out_var"},  out_var, 32'h0);
      check({tag, "_bvalid"},   {31'd0, block_valid}, 32'h0);
      check({tag, "_full"},     {31'd0, full}, 32'h0);
      check({tag, "_word_cnt"}, {27'd0, word_cnt}, 32'h0);
      check({tag, "_wr_err"},   {31'd0, wr_err}, 32'h0);
      check({tag, "_load_err"}, {31'd0, load_err}, 32'h0);
   endtask

   initial begin
      checks   = 0;
      failures = 0;
      rst = 1'b1; addr = 4'd0; we = 1'b0; in_var = 32'h0;
      load = 1'b0; rd_addr = 4'd0; ack = 1'b0;
      step();
      step();
      rst = 1'b0;
      check_reset_outputs("reset");

      // 1: full block, commit, read back
      for (int k = 0; k < 16; k++) begin
         write_word(k[3:0], 32'h61626380 + k);
         if (k == 14) begin
            check("t1_cnt15", {27'd0, word_cnt}, 32'd15);
            check("t1_notfull", {31'd0, full}, 32'd0);
         end
      end
      check("t1_cnt16", {27'd0, word_cnt}, 32'd16);
      check("t1_full", {31'd0, full}, 32'd1);
      check("t1_bv_before", {31'd0, block_valid}, 32'd0);
      load = 1'b1;
      step();
      load = 1'b0;
      check("t1_bv", {31'd0, block_valid}, 32'd1);
      check("t1_no_lerr", {31'd0, load_err}, 32'd0);
      rd_addr = 4'd5;
      step();
      check("t1_rd5", out_var, 32'h61626385);
      ack = 1'b1;
      step();
      ack = 1'b0;
      check("t1_ack_bv", {31'd0, block_valid}, 32'd0);
      check("t1_ack_cnt", {27'd0, word_cnt}, 32'd0);

      // 2: incomplete load, then write+load in the same cycle
      for (int k = 0; k < 15; k++) begin
         write_word(k[3:0], 32'h00001000 + k);
      end
      load = 1'b1;
      step();
      load = 1'b0;
      check("t2_lerr", {31'd0, load_err}, 32'd1);
      check("t2_bv0", {31'd0, block_valid}, 32'd0);
      check("t2_cnt15", {27'd0, word_cnt}, 32'd15);
      step();
      check("t2_lerr_1cyc", {31'd0, load_err}, 32'd0);
      addr = 4'd15; in_var = 32'h0000100F; we = 1'b1; load = 1'b1;
      step();
      we = 1'b0; load = 1'b0;
      check("t2_bv1", {31'd0, block_valid}, 32'd1);
      check("t2_no_lerr", {31'd0, load_err}, 32'd0);
      check("t2_full", {31'd0, full}, 32'd1);

      // 3: write in READY is dropped and flagged, then release
      write_word(4'd3, 32'hDEADBEEF);
      check("t3_wrerr", {31'd0, wr_err}, 32'd1);
      rd_addr = 4'd3;
      step();
      check("t3_wrerr_1cyc", {31'd0, wr_err}, 32'd0);
      check("t3_rd3", out_var, 32'h00001003);
      ack = 1'b1;
      step();
      ack = 1'b0;
      check("t3_bv0", {31'd0, block_valid}, 32'd0);
      check("t3_cnt0", {27'd0, word_cnt}, 32'd0);
      check("t3_full0", {31'd0, full}, 32'd0);

      // 4: rewrite of one index counts once, last data wins
      write_word(4'd7, 32'h11111111);
      write_word(4'd7, 32'h22222222);
      check("t4_cnt1", {27'd0, word_cnt}, 32'd1);
      for (int k = 0; k < 16; k++) begin
         if (k != 7) begin
            write_word(k[3:0], 32'h00003000 + k);
         end
      end
      check("t4_cnt16", {27'd0, word_cnt}, 32'd16);
      load = 1'b1;
      rd_addr = 4'd7;
      step();
      load = 1'b0;
      check("t4_bv", {31'd0, block_valid}, 32'd1);
      step();
      check("t4_rd7", out_var, 32'h22222222);

      // 5: ack + we + load together in READY: ack wins, others flagged
      ack = 1'b1; we = 1'b1; load = 1'b1; addr = 4'd0; in_var = 32'hCAFEF00D;
      step();
      ack = 1'b0; we = 1'b0; load = 1'b0;
      check("t5_bv0", {31'd0, block_valid}, 32'd0);
      check("t5_wrerr", {31'd0, wr_err}, 32'd1);
      check("t5_lerr", {31'd0, load_err}, 32'd1);
      check("t5_cnt0", {27'd0, word_cnt}, 32'd0);
      rd_addr = 4'd0;
      step();
      check("t5_errs_clear", {30'd0, wr_err, load_err}, 32'd0);
      check("t5_rd0_kept", out_var, 32'h00003000);
      write_word(4'd2, 32'h0000ABCD);
      ack = 1'b1;
      step();
      ack = 1'b0;
      check("t5_fill_ack_cnt", {27'd0, word_cnt}, 32'd1);
      check("t5_fill_ack_err", {30'd0, wr_err, load_err}, 32'd0);
      check("t5_fill_ack_bv", {31'd0, block_valid}, 32'd0);

      // 6: reset in READY with load pending
      fill_and_load(32'h00005000);
      check("t6_bv", {31'd0, block_valid}, 32'd1);
      check("t6_cnt16", {27'd0, word_cnt}, 32'd16);
      rst = 1'b1; load = 1'b1;
      step();
      rst = 1'b0; load = 1'b0;
      check_reset_outputs("t6_rst");
      step();
      check("t6_stay_fill", {31'd0, block_valid}, 32'd0);
      load = 1'b1;
      step();
      load = 1'b0;
      check("t6_mask_empty_lerr", {31'd0, load_err}, 32'd1);
      check("t6_bv_after", {31'd0, block_valid}, 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
